// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler: FSM encoding and
// the wrap-around priority pick used by rr_pick.
package mux_rr_scheduler_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // The pick function works on a fixed maximum width so that it can live in the
  // package; callers zero-extend their request/pointer and narrow the result.
  localparam int PICK_MAX_K = 8;
  localparam int PICK_MAX_N = 1 << PICK_MAX_K;

  typedef struct packed {
    logic                  found;
    logic [PICK_MAX_K-1:0] idx;
  } pick_t;

  // First set request bit at or after ptr, scanning upward and wrapping modulo n
  // (n must be a power of two). Scanning from the far end down means the last
  // hit written is the one closest to ptr.
  function automatic pick_t rr_pick_fn(input logic [PICK_MAX_N-1:0] req,
                                       input logic [PICK_MAX_K-1:0] ptr,
                                       input int                    n);
    pick_t                 res;
    logic [PICK_MAX_K-1:0] cand;
    res.found = 1'b0;
    res.idx   = {PICK_MAX_K{1'b0}};
    for (int i = PICK_MAX_N - 1; i >= 0; i--) begin
      cand = PICK_MAX_K'((int'(ptr) + i) & (n - 1));
      if ((i < n) && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: finds the first requester at or after
// the priority pointer, wrapping around the requester ring.
module rr_pick #(
  parameter int K = 2
) (
  input  logic [(1<<K)-1:0] req,
  input  logic [K-1:0]      ptr,
  output logic              found,
  output logic [K-1:0]      idx
);
  import mux_rr_scheduler_pkg::*;

  localparam int N = 1 << K;

  pick_t pick_s;
  logic  unused_idx_s;

  // Widen to the shared function's size, pick, and narrow the index back to K bits.
  always_comb begin
    pick_s       = rr_pick_fn(PICK_MAX_N'(req), PICK_MAX_K'(ptr), N);
    found        = pick_s.found;
    idx          = pick_s.idx[K-1:0];
    unused_idx_s = ^pick_s.idx;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 2**K-input mux among 2**K requesters.
// Grants one requester at a time, drives the registered mux select, and
// releases on done, request withdrawal, or the MAX_HOLD limit. A one-cycle
// IDLE bubble always separates consecutive grants.
module mux_rr_scheduler #(
  parameter int K        = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [(1<<K)-1:0] req,
  input  logic              done,
  output logic [K-1:0]      sel,
  output logic [(1<<K)-1:0] grant,
  output logic              grant_valid,
  output logic              timeout,
  output logic              busy
);
  import mux_rr_scheduler_pkg::*;

  localparam int            N         = 1 << K;
  // Last counter value of a grant; only meaningful when MAX_HOLD is nonzero.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_r, state_nxt_s;
  logic [K-1:0]  sel_r, sel_nxt_s;
  logic [N-1:0]  grant_r, grant_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          timeout_r, timeout_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [K-1:0]  ptr_r, ptr_nxt_s;

  logic          pick_found_s;
  logic [K-1:0]  pick_idx_s;
  logic          limit_hit_s;
  logic          release_s;

  rr_pick #(.K(K)) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Release priority: done, then withdrawal of the granted request, then hold limit.
  assign limit_hit_s = (MAX_HOLD != 0) && (cnt_r == HOLD_LAST);
  assign release_s   = done || !req[sel_r] || limit_hit_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: grant whenever anyone requests, always fall back to IDLE on release.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; grant, valid and timeout default to zero so
  // they only assert while actively held or on the forced-release edge.
  always_comb begin
    sel_nxt_s     = sel_r;
    grant_nxt_s   = {N{1'b0}};
    valid_nxt_s   = 1'b0;
    timeout_nxt_s = 1'b0;
    cnt_nxt_s     = {CW{1'b0}};
    ptr_nxt_s     = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          sel_nxt_s   = pick_idx_s;
          grant_nxt_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
          valid_nxt_s = 1'b1;
        end else begin
          sel_nxt_s   = sel_r;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          // Pointer moves past the released requester; sel keeps its value.
          ptr_nxt_s     = sel_r + K'(1'b1);
          timeout_nxt_s = limit_hit_s && !done && req[sel_r];
        end else begin
          grant_nxt_s   = grant_r;
          valid_nxt_s   = 1'b1;
          cnt_nxt_s     = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        ptr_nxt_s = {K{1'b0}};
      end
    endcase
  end

  // Registered outputs, hold counter and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r     <= {K{1'b0}};
      grant_r   <= {N{1'b0}};
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      ptr_r     <= {K{1'b0}};
    end else begin
      sel_r     <= sel_nxt_s;
      grant_r   <= grant_nxt_s;
      valid_r   <= valid_nxt_s;
      timeout_r <= timeout_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ptr_r     <= ptr_nxt_s;
    end
  end

  assign sel         = sel_r;
  assign grant       = grant_r;
  assign grant_valid = valid_r;
  assign timeout     = timeout_r;
  assign busy        = (state_r == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed self-checking bench for mux_rr_scheduler (K=2, MAX_HOLD=4).
// Expected grant/sel/timeout are hand-computed per step; grant_valid and busy
// are expected to equal |grant.
module tb_mux_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  mux_rr_scheduler #(.K(2), .MAX_HOLD(4), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {sel, grant, grant_valid, timeout, busy} against the expectation.
  task automatic check_out(input string tag, input logic [3:0] eg,
                           input logic [1:0] es, input logic et);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {sel, grant, grant_valid, timeout, busy};
    exp = {es, eg, |eg, et, |eg};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {sel,grant,gv,to,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // 1. Reset mid-grant, then recover.
    req = 4'b0100;
    tick();
    check_out("t1_grant", 4'b0100, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("t1_async_reset", 4'b0000, 2'd0, 1'b0);
    #1 rst = 1'b0;
    req = 4'b0001;
    tick();
    check_out("t1_regrant", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t1_release", 4'b0000, 2'd0, 1'b0);

    // 2. Single requester, done on the third grant cycle (ptr 1 -> 3).
    req = 4'b0100;
    tick();
    check_out("t2_c1", 4'b0100, 2'd2, 1'b0);
    tick();
    check_out("t2_c2", 4'b0100, 2'd2, 1'b0);
    tick();
    check_out("t2_c3", 4'b0100, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    check_out("t2_release", 4'b0000, 2'd2, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_out("t2_idle_sel_hold", 4'b0000, 2'd2, 1'b0);

    // 6. Wrap from ptr=3, done ignored in IDLE, done/limit collision.
    req = 4'b1001;
    tick();
    check_out("t6_wrap_first", 4'b1000, 2'd3, 1'b0);
    done = 1'b1;
    tick();
    check_out("t6_release", 4'b0000, 2'd3, 1'b0);
    tick();
    check_out("t6_wrap_second", 4'b0001, 2'd0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t6_hold", 4'b0001, 2'd0, 1'b0);
    end
    done = 1'b1;
    tick();
    check_out("t6_collision", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_out("t6_idle", 4'b0000, 2'd0, 1'b0);

    // Reset to bring the pointer back to 0.
    rst = 1'b1;
    tick();
    check_out("reset2", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // 3. Round-robin rotation with all requesting and done held high.
    req  = 4'b1111;
    done = 1'b1;
    tick(); check_out("t3_g0", 4'b0001, 2'd0, 1'b0);
    tick(); check_out("t3_b0", 4'b0000, 2'd0, 1'b0);
    tick(); check_out("t3_g1", 4'b0010, 2'd1, 1'b0);
    tick(); check_out("t3_b1", 4'b0000, 2'd1, 1'b0);
    tick(); check_out("t3_g2", 4'b0100, 2'd2, 1'b0);
    tick(); check_out("t3_b2", 4'b0000, 2'd2, 1'b0);
    tick(); check_out("t3_g3", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("t3_b3", 4'b0000, 2'd3, 1'b0);
    tick(); check_out("t3_g0_again", 4'b0001, 2'd0, 1'b0);
    req  = 4'b0000;
    done = 1'b0;
    tick();
    check_out("t3_release", 4'b0000, 2'd0, 1'b0);

    // 4. Timeout after four held cycles (ptr=1).
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("t4_hold", 4'b0010, 2'd1, 1'b0);
    end
    tick();
    check_out("t4_timeout", 4'b0000, 2'd1, 1'b1);
    tick();
    check_out("t4_regrant", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t4_withdraw", 4'b0000, 2'd1, 1'b0);

    // 5. Withdrawal after one cycle (ptr=2); pointer must move past index 2.
    req = 4'b0110;
    tick();
    check_out("t5_grant", 4'b0100, 2'd2, 1'b0);
    req = 4'b0010;
    tick();
    check_out("t5_release", 4'b0000, 2'd2, 1'b0);
    req = 4'b0110;
    tick();
    check_out("t5_ptr_advanced", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t5_idle", 4'b0000, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
